// File: rtl/im_loader_pkg.sv
// Shared constants and types for the instruction-memory loader.
package im_loader_pkg;

  localparam logic [1:0]  FMT_R    = 2'd0;
  localparam logic [1:0]  FMT_I    = 2'd1;
  localparam logic [1:0]  FMT_J    = 2'd2;
  localparam logic [1:0]  FMT_ILL  = 2'd3;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/im_loader_if.sv
// Decoded-instruction handshake between the host program source and the loader.
interface im_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [1:0]  in_fmt;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] target;

  modport master (
    output in_valid, in_last, in_fmt, opcode, rs, rt, rd, shamt, funct, imm, target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_fmt, opcode, rs, rt, rd, shamt, funct, imm, target,
    output in_ready
  );

endinterface

// File: rtl/im_loader_instr_encoder.sv
// Combinational MIPS field packer: selects the R/I/J layout by format and
// flags the reserved format, which packs to a nop.
module instr_encoder
  import im_loader_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // Pack fields according to the instruction format.
  always_comb begin
    word    = NOP_WORD;
    illegal = 1'b0;
    case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      FMT_I:   word = {opcode, rs, rt, imm};
      FMT_J:   word = {opcode, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: accepts decoded instructions over a valid/ready
// handshake, packs them and writes them to consecutive IM word addresses
// while holding the IFU in reset.
// Optional build macro IM_LOADER_CHECKSUM_EN adds a running XOR checksum
// output (csum) of every word written in the session.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no session; IFU released; waits for start
// ST_LOAD  | accepting beats; each accepted beat is written next cycle
// ST_DRAIN | last/overflow seen; final pending write completes
// ST_DONE  | one-cycle done pulse; IFU released on the following cycle
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  im_loader_if.slave        ib,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
`ifdef IM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        ready;
  logic        accept;
  logic        wr_fire;

  instr_encoder u_enc (
    .fmt     (ib.in_fmt),
    .opcode  (ib.opcode),
    .rs      (ib.rs),
    .rt      (ib.rt),
    .rd      (ib.rd),
    .shamt   (ib.shamt),
    .funct   (ib.funct),
    .imm     (ib.imm),
    .target  (ib.target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign ready   = (state_q == ST_LOAD) && (count_q < DEPTH);
  assign accept  = ib.in_valid && ready;
  // abort squashes a write already registered for this cycle
  assign wr_fire = we_q && !abort;

  assign ib.in_ready = ready;
  assign im_we       = wr_fire;
  assign im_addr     = addr_q;
  assign im_wdata    = wdata_q;
  assign cpu_hold    = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE) && !abort;
  assign count       = count_q;
  assign err         = err_q;
`ifdef IM_LOADER_CHECKSUM_EN
  assign csum        = csum_q;
`endif

  // Next-state, write pipeline and session bookkeeping.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    err_d   = err_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    // completed write advances the address for the next word
    if (wr_fire) begin
      addr_d = addr_q + ADR_ONE;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_d = csum_q ^ wdata_q;
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          count_d = '0;
          err_d   = 1'b0;
          addr_d  = BASE;
`ifdef IM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // count tracks words committed to the write pipeline so in_ready
          // drops as soon as the last free slot is taken
          we_d    = 1'b1;
          wdata_d = enc_word;
          count_d = count_q + CNT_ONE;
          if (enc_illegal) err_d = 1'b1;
          if (ib.in_last)  state_d = ST_DRAIN;
        end else if (ib.in_valid && (count_q == DEPTH)) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // abort overrides everything: nothing new is recorded and a pending
    // write is withdrawn from the count
    if (abort) begin
      state_d = ST_IDLE;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      count_d = count_q - {{ADDR_W{1'b0}}, we_q};
`ifdef IM_LOADER_CHECKSUM_EN
      csum_d  = csum_q;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef IM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: session-level reference model checked every cycle,
// directed literal cases, then randomized sessions with aborts and overflow.
module tb_im_loader;

  localparam int ADDR_W    = 2;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [31:0]       csum;
`endif

  im_loader_if ib ();

  im_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ib       (ib),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .count    (count),
    .err      (err)
`ifdef IM_LOADER_CHECKSUM_EN
    ,
    .csum     (csum)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // MIPS layout expressed as field weights
  function automatic logic [31:0] pack(input int unsigned fmt, input int unsigned op,
                                       input int unsigned rs, input int unsigned rt,
                                       input int unsigned rd, input int unsigned sh,
                                       input int unsigned fn, input int unsigned imm,
                                       input int unsigned tgt);
    int unsigned w;
    case (fmt)
      0:       w = op * 32'h0400_0000 + rs * 32'h20_0000 + rt * 32'h1_0000
                   + rd * 32'h800 + sh * 32'h40 + fn;
      1:       w = op * 32'h0400_0000 + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
      2:       w = op * 32'h0400_0000 + tgt;
      default: w = 0;
    endcase
    return w;
  endfunction

  // reference model: session-level view of what the loader must show
  bit          m_load;
  int          m_tail;      // cycles of wind-down left after the session closes
  int          m_ndone;     // words whose write has completed
  bit          m_pend;      // a word is scheduled to be written this cycle
  logic [31:0] m_pword;
  int          m_paddr;
  bit          m_err;
  logic [31:0] m_csum;

  int          ndone_seen = 0;
  logic [31:0] log_w[$];
  int          log_a[$];

  always @(negedge clk) begin : mon
    int cnt_before;
    bit rdy;
    bit sess;
    if (!rst) begin
      chk("rst_in_ready", 32'(ib.in_ready), 0);
      chk("rst_im_we",    32'(im_we),       0);
      chk("rst_cpu_hold", 32'(cpu_hold),    0);
      chk("rst_done",     32'(done),        0);
      chk("rst_err",      32'(err),         0);
      chk("rst_count",    32'(count),       0);
      chk("rst_im_addr",  32'(im_addr),     32'(BASE_ADDR));
      chk("rst_im_wdata", im_wdata,         0);
      m_load = 0; m_tail = 0; m_ndone = 0; m_pend = 0;
      m_pword = 0; m_paddr = 0; m_err = 0; m_csum = 0;
    end else begin
      cnt_before = m_ndone + int'(m_pend);
      rdy        = m_load && (cnt_before < DEPTH);
      sess       = m_load || (m_tail > 0);
      chk("in_ready", 32'(ib.in_ready), 32'(rdy));
      chk("im_we",    32'(im_we),       32'(m_pend && !abort));
      chk("cpu_hold", 32'(cpu_hold),    32'(sess));
      chk("done",     32'(done),        32'((m_tail == 1) && !abort));
      chk("err",      32'(err),         32'(m_err));
      if (!abort) chk("count", 32'(count), 32'(cnt_before));
      if (m_pend && !abort) begin
        chk("im_addr",  32'(im_addr), 32'(m_paddr));
        chk("im_wdata", im_wdata,     m_pword);
      end
`ifdef IM_LOADER_CHECKSUM_EN
      chk("csum", csum, m_csum);
`endif
      if (im_we === 1'b1) begin
        log_w.push_back(im_wdata);
        log_a.push_back(int'(im_addr));
      end
      if (done === 1'b1) ndone_seen++;

      if (abort) begin
        m_load = 0; m_tail = 0; m_pend = 0;
      end else begin
        if (m_pend) begin
          m_ndone++;
          m_csum = m_csum ^ m_pword;
          m_pend = 0;
        end
        if (m_tail > 0) m_tail--;
        if (!sess) begin
          if (start) begin
            m_load = 1; m_ndone = 0; m_err = 0; m_csum = 0;
          end
        end else if (m_load) begin
          if (ib.in_valid && rdy) begin
            m_pend  = 1;
            m_pword = pack(ib.in_fmt, ib.opcode, ib.rs, ib.rt, ib.rd, ib.shamt,
                           ib.funct, ib.imm, ib.target);
            m_paddr = (BASE_ADDR + cnt_before) % DEPTH;
            if (ib.in_fmt == 2'd3) m_err = 1;
            if (ib.in_last) begin m_load = 0; m_tail = 2; end
          end else if (ib.in_valid) begin
            m_err = 1; m_load = 0; m_tail = 2;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic set_fields(input int fmt, input int op, input int rs, input int rt,
                            input int rd, input int sh, input int fn, input int imm,
                            input int tgt);
    ib.in_fmt = 2'(fmt); ib.opcode = 6'(op); ib.rs = 5'(rs); ib.rt = 5'(rt);
    ib.rd = 5'(rd); ib.shamt = 5'(sh); ib.funct = 6'(fn); ib.imm = 16'(imm);
    ib.target = 26'(tgt);
  endtask

  task automatic rand_fields();
    set_fields(($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2)),
               int'($urandom_range(0, 63)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 65535)), int'($urandom_range(0, 32'h3FF_FFFF)));
  endtask

  // hold one beat until accepted or the session ends
  task automatic beat(input bit last, output bit acc);
    bit r, h;
    acc = 0;
    ib.in_valid = 1'b1;
    ib.in_last  = last;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      r = ib.in_ready;
      h = cpu_hold;
      cyc();
      if (r) begin acc = 1; break; end
      if (!h) break;
    end
    ib.in_valid = 1'b0;
    ib.in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!cpu_hold) begin ok = 1; break; end
    end
    chk("idle_timeout", 32'(ok), 1);
    cyc();
  endtask

  task automatic rand_session();
    int nb, i;
    bit r, h, prev_r, fresh;
    nb = int'($urandom_range(1, 6));
    pulse_start();
    i = 0; prev_r = 0; fresh = 1;
    for (int g = 0; g < 40; g++) begin
      if (fresh) rand_fields();
      ib.in_valid = ($urandom_range(0, 3) != 0);
      ib.in_last  = (i == nb - 1);
      abort       = ($urandom_range(0, 24) == 0);
      start       = prev_r && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      r = ib.in_ready;
      h = cpu_hold;
      cyc();
      start = 1'b0;
      prev_r = r;
      if (abort) begin abort = 1'b0; break; end
      fresh = ib.in_valid && r;
      if (fresh) begin
        i++;
        if (i == nb) break;
      end
      if (!h) break;
    end
    ib.in_valid = 1'b0;
    ib.in_last  = 1'b0;
    wait_idle();
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit acc;
    int nd0;
    logic [31:0] w0;
    ib.in_valid = 1'b0;
    ib.in_last  = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_cpu_hold", 32'(cpu_hold), 0);
    chk("lit_rst_im_we",    32'(im_we),    0);
    @(posedge clk); #1;
    rst = 1'b1;
    cyc();

    // addu $3,$1,$2
    log_w.delete(); log_a.delete(); nd0 = ndone_seen;
    pulse_start();
    set_fields(0, 0, 1, 2, 3, 0, 'h21, 0, 0);
    beat(1, acc);
    wait_idle();
    chk("addu_nwrites", 32'(log_w.size()), 1);
    if (log_w.size() > 0) begin
      chk("addu_addr",  32'(log_a[0]), 0);
      chk("addu_wdata", log_w[0],      32'h0022_1821);
    end
    chk("addu_done",  32'(ndone_seen - nd0), 1);
    chk("addu_count", 32'(count), 1);

    // ori then j
    log_w.delete(); log_a.delete();
    pulse_start();
    set_fields(1, 'h0D, 0, 1, 0, 0, 0, 'h1234, 0);
    beat(0, acc);
    set_fields(2, 2, 0, 0, 0, 0, 0, 0, 'h0000C00);
    beat(1, acc);
    wait_idle();
    chk("ij_nwrites", 32'(log_w.size()), 2);
    if (log_w.size() > 1) begin
      chk("ori_addr",  32'(log_a[0]), 0);
      chk("ori_wdata", log_w[0],      32'h3401_1234);
      chk("j_addr",    32'(log_a[1]), 1);
      chk("j_wdata",   log_w[1],      32'h0800_0C00);
    end

    // overflow: five beats into four slots
    log_w.delete(); log_a.delete(); nd0 = ndone_seen;
    pulse_start();
    for (int b = 0; b < 5; b++) begin
      set_fields(0, 0, b, b + 1, b + 2, 0, 'h21, 0, 0);
      beat(0, acc);
      if (b == 4) chk("ovf_5th_accepted", 32'(acc), 0);
    end
    wait_idle();
    chk("ovf_nwrites", 32'(log_w.size()), 4);
    for (int b = 0; b < 4; b++)
      if (b < log_a.size()) chk("ovf_addr", 32'(log_a[b]), 32'(b));
    chk("ovf_err",   32'(err), 1);
    chk("ovf_done",  32'(ndone_seen - nd0), 1);
    chk("ovf_count", 32'(count), 4);

    // illegal format mid-stream
    log_w.delete(); log_a.delete();
    pulse_start();
    set_fields(0, 0, 4, 5, 6, 0, 'h20, 0, 0);
    beat(0, acc);
    set_fields(3, 'h3F, 31, 31, 31, 31, 'h3F, 'hFFFF, 'h3FFFFFF);
    beat(0, acc);
    set_fields(1, 'h08, 1, 2, 0, 0, 0, 'hFFFF, 0);
    beat(1, acc);
    wait_idle();
    chk("ill_nwrites", 32'(log_w.size()), 3);
    if (log_w.size() > 2) begin
      chk("ill_w0", log_w[0], 32'h0085_3020);
      chk("ill_w1", log_w[1], 32'h0000_0000);
      chk("ill_a1", 32'(log_a[1]), 1);
      chk("ill_w2", log_w[2], 32'h2022_FFFF);
    end
    chk("ill_err", 32'(err), 1);

    // abort the cycle after a beat is accepted
    log_w.delete(); log_a.delete(); nd0 = ndone_seen;
    pulse_start();
    set_fields(0, 0, 7, 8, 9, 0, 'h21, 0, 0);
    ib.in_valid = 1'b1;
    cyc();
    ib.in_valid = 1'b0;
    abort = 1'b1;
    #2;
    chk("abort_im_we", 32'(im_we), 0);
    chk("abort_done",  32'(done),  0);
    cyc();
    abort = 1'b0;
    chk("abort_cpu_hold", 32'(cpu_hold), 0);
    chk("abort_count",    32'(count),    0);
    chk("abort_nwrites",  32'(log_w.size()), 0);
    chk("abort_ndone",    32'(ndone_seen - nd0), 0);
    cyc();

    // asynchronous reset in the middle of a load
    pulse_start();
    set_fields(0, 0, 10, 11, 12, 3, 'h00, 0, 0);
    w0 = pack(0, 0, 10, 11, 12, 3, 0, 0, 0);
    beat(0, acc);
    set_fields(2, 3, 0, 0, 0, 0, 0, 0, 'h155);
    beat(0, acc);
    chk("prerst_im_we", 32'(im_we), 1);
`ifdef IM_LOADER_CHECKSUM_EN
    chk("prerst_csum", csum, w0);
`endif
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_im_we",    32'(im_we),       0);
    chk("midrst_cpu_hold", 32'(cpu_hold),    0);
    chk("midrst_in_ready", 32'(ib.in_ready), 0);
    chk("midrst_count",    32'(count),       0);
    cyc();
    rst = 1'b1;
    cyc();

    for (int s = 0; s < 150; s++) rand_session();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
